// File: rtl/risc_mgmt_mem_arbiter.sv
// Memory-port arbiter for the RISC-MGMT extension array: fixed-priority grant,
// multi-cycle access FSM against the pipeline busy handshake, timeout abort and exception reporting.
module risc_mgmt_mem_arbiter #(
    parameter int NUM_EXT     = 4,
    parameter int DATA_W      = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [NUM_EXT-1:0]        ext_active,
    input  logic [NUM_EXT-1:0]        ext_req_mem,
    input  logic [NUM_EXT-1:0]        ext_mem_ren,
    input  logic [NUM_EXT-1:0]        ext_mem_wen,
    input  logic [NUM_EXT*DATA_W-1:0] ext_mem_addr,
    input  logic [NUM_EXT*DATA_W-1:0] ext_mem_wdata,
    input  logic [NUM_EXT-1:0]        ext_exception,
    output logic [NUM_EXT-1:0]        ext_mem_done,
    output logic [DATA_W-1:0]         ext_mem_rdata,
    output logic [NUM_EXT-1:0]        grant,
    output logic [DATA_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_ren,
    output logic                      mem_wen,
    input  logic                      mem_busy,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      execute_stall,
    output logic                      exception,
    output logic [NUM_EXT-1:0]        ex_cause,
    output logic                      timeout_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_EXT-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                exception_q, exception_d;
    logic [NUM_EXT-1:0]  ex_cause_q, ex_cause_d;
    logic                timeout_err_q, timeout_err_d;

    logic [NUM_EXT-1:0]  cand;
    logic [NUM_EXT-1:0]  cand_lowest;
    logic [DATA_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                owner_wen;
    logic [CNT_W-1:0]    cnt_inc;
    logic                in_access;
    logic                abort;

    assign cand        = ext_active & ext_req_mem & (ext_mem_ren | ext_mem_wen);
    // Two's-complement trick isolates the lowest set bit: lowest index wins.
    assign cand_lowest = cand & (~cand + NUM_EXT'(1));
    assign in_access   = (state_q == ST_ACCESS);
    assign owner_wen   = |(grant_q & ext_mem_wen);
    assign cnt_inc     = (cnt_q == CNT_W'(MEM_TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
    assign abort       = in_access && mem_busy && (cnt_inc == CNT_W'(MEM_TIMEOUT));

    // One-hot grant, so OR-ing the masked slices is a plain mux.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_EXT; i++) begin
            if (grant_q[i]) begin
                sel_addr  = sel_addr  | ext_mem_addr[i*DATA_W +: DATA_W];
                sel_wdata = sel_wdata | ext_mem_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cand != '0) begin
                    grant_d = cand_lowest;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_inc;
                if (!mem_busy) begin
                    rdata_d = mem_rdata;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else if (abort) begin
                    cnt_d   = '0;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A timeout abort ORs the lost owner into whatever the extensions report this cycle.
    always_comb begin
        ex_cause_d    = (ext_exception & ext_active) | (abort ? grant_q : '0);
        exception_d   = |ex_cause_d;
        timeout_err_d = abort;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            exception_q   <= 1'b0;
            ex_cause_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            grant_q       <= grant_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            exception_q   <= exception_d;
            ex_cause_q    <= ex_cause_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign grant         = grant_q;
    assign ext_mem_done  = (state_q == ST_DONE) ? grant_q : '0;
    assign ext_mem_rdata = rdata_q;
    assign mem_addr      = in_access ? sel_addr  : '0;
    assign mem_wdata     = in_access ? sel_wdata : '0;
    assign mem_wen       = in_access &&  owner_wen;
    assign mem_ren       = in_access && !owner_wen;
    // Held low while in reset so every output reads 0 during nRST.
    assign execute_stall = nRST && ((state_q != ST_IDLE) || (cand != '0));
    assign exception     = exception_q;
    assign ex_cause      = ex_cause_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: doc/risc_mgmt_mem_arbiter.md
Name: risc_mgmt_mem_arbiter

Overview:
Parametrised successor to the single-channel RISC-MGMT/pipeline handshake. It arbitrates up to NUM_EXT extensions for one memory port and runs a multi-cycle access FSM against the pipeline's busy handshake. It also drives the execute-stage stall, aborts hung accesses on timeout, and reports registered, one-hot exception causes. It sits between the extension array and the two-stage pipeline's memory/hazard logic.

Parameters:
NUM_EXT, 4, number of attached extensions (1..16)
DATA_W, 32, address/data word width
MEM_TIMEOUT, 255, max ACCESS cycles before abort (>=2)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
ext_active  input  NUM_EXT  extension i claims the current insn
ext_req_mem  input  NUM_EXT  extension i requests a memory access
ext_mem_ren  input  NUM_EXT  read request qualifier
ext_mem_wen  input  NUM_EXT  write request qualifier
ext_mem_addr  input  NUM_EXT*DATA_W  packed addresses, slice i = [i*DATA_W +: DATA_W]
ext_mem_wdata  input  NUM_EXT*DATA_W  packed store data
ext_exception  input  NUM_EXT  extension i raises an exception
ext_mem_done  output  NUM_EXT  one-cycle completion pulse to the granted extension
ext_mem_rdata  output  DATA_W  registered load data, broadcast
grant  output  NUM_EXT  one-hot current owner, 0 when idle
mem_addr  output  DATA_W  to pipeline memory port
mem_wdata  output  DATA_W  to pipeline memory port
mem_ren  output  1  read strobe
mem_wen  output  1  write strobe
mem_busy  input  1  pipeline memory busy
mem_rdata  input  DATA_W  pipeline load data
execute_stall  output  1  stall execute stage
exception  output  1  registered exception flag
ex_cause  output  NUM_EXT  registered one-hot cause
timeout_err  output  1  registered: exception was a timeout

Behaviour:
- Reset (async, nRST=0): state=IDLE, timeout counter=0. All outputs 0, including ext_mem_rdata. Reset mid-access aborts immediately; no done pulse is issued.
- Eligible request vector: cand = ext_active & ext_req_mem & (ext_mem_ren | ext_mem_wen).
- States IDLE, ACCESS, DONE.
- IDLE: if cand != 0, register grant = lowest-index set bit of cand, then go to ACCESS. A requester with ren=wen=0 is ignored.
- ACCESS:
  - mem_addr and mem_wdata come from the granted slice, combinationally.
  - If the owner's wen=1, mem_wen=1 and mem_ren=0. Write has precedence when ren and wen are both set.
  - Otherwise mem_ren=1.
  - Counter increments each ACCESS cycle.
  - When mem_busy=0: capture ext_mem_rdata<=mem_rdata (also on writes), clear the counter, go to DONE.
- DONE (1 cycle): ext_mem_done = grant; strobes 0; next state IDLE and grant cleared. Back-to-back requests therefore have at least one idle cycle between DONE and the next ACCESS.
- Timeout: if the counter reaches MEM_TIMEOUT while mem_busy=1, go to IDLE, clear grant and counter, no done pulse. Next cycle: exception=1, ex_cause=old grant, timeout_err=1.
- Grant is held constant through ACCESS/DONE even if the owner drops ext_active or ext_req_mem. Other requests wait; there is no preemption.
- execute_stall = (state!=IDLE) | (state==IDLE & cand!=0). Combinational, so the stall asserts in the request cycle.
- Exception register, updated every cycle:
  - ex_cause <= ext_exception & ext_active; exception <= |that; timeout_err <= 0.
  - The timeout path overrides this for the cycle following the abort.
  - Simultaneous timeout and extension exceptions: ex_cause = OR of both, timeout_err=1.
- ext_mem_rdata holds its value until the next capture.
- Counter width = clog2(MEM_TIMEOUT+1) and never wraps.

Test Plan:
- Single read: ext1 active, ren, addr 0x1000; mem_busy high 3 cycles then low with rdata 0xDEADBEEF -> grant=0010, mem_ren high 4 cycles, ext_mem_rdata=0xDEADBEEF, ext_mem_done=0010 for exactly 1 cycle, execute_stall drops the cycle after DONE.
- Contention: ext0 and ext2 request writes in the same cycle -> ext0 served first (mem_wen, its addr/wdata), then one idle cycle, then ext2. Grant sequence 0001, 0000, 0100.
- Ren+wen both set on ext3 -> mem_wen=1, mem_ren=0.
- Timeout with MEM_TIMEOUT=4 and mem_busy stuck high -> ACCESS lasts 4 cycles, then IDLE. Next cycle: exception=1, ex_cause=granted bit, timeout_err=1, no done pulse.
- Exception masking: ext_exception=1010, ext_active=0010 -> next cycle ex_cause=0010, exception=1, timeout_err=0.
- nRST pulsed low mid-ACCESS -> all outputs 0 asynchronously, state IDLE; a fresh request after release completes normally.
